clic_trig_gateway: RTL and testbench

CLIC_TRIG_GATEWAY -- requirements
Module: clic_trig_gateway

---
 rtl/clic_trig_gateway.sv | 110 +++++++++++
 tb/tb_clic_trig_gateway.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/clic_trig_gateway.sv
// CLIC trigger gateway: synchronises raw interrupt lines and turns them into level
// or edge pending bits, with software write and core acknowledge on edge sources.

module clic_trig_lane #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       warm_i,
    input  logic       src_i,
    input  logic [1:0] trig_i,
    input  logic       sw_we_i,
    input  logic       sw_d_i,
    input  logic       ack_i,
    output logic       ip_o,
    output logic       ip_de_o
);
    logic s, lvl, prv, edge_det, ip_nxt;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = src_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk_i) begin
                if (!rst_ni) sync_q <= '0;
                else         sync_q <= SYNC_STAGES'({sync_q, src_i});
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Until the synchroniser has refilled after reset its output is stale zeros,
    // so the line is ignored and prv stays high: a line already active never edges.
    always_comb begin
        lvl      = s ^ trig_i[1];
        edge_det = warm_i & lvl & ~prv;
        ip_nxt   = ip_o;
        if (!trig_i[0]) begin
            if (warm_i) ip_nxt = lvl;
        end else if (edge_det) begin
            ip_nxt = 1'b1;
        end else if (sw_we_i) begin
            ip_nxt = sw_d_i;
        end else if (ack_i) begin
            ip_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prv     <= 1'b1;
            ip_o    <= 1'b0;
            ip_de_o <= 1'b0;
        end else begin
            if (warm_i) prv <= lvl;
            ip_o    <= ip_nxt;
            ip_de_o <= ip_nxt ^ ip_o;
        end
    end
endmodule

module clic_trig_gateway #(
    parameter int N_SOURCE    = 32,
    parameter int SYNC_STAGES = 2,
    localparam int IDW        = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_SOURCE-1:0]      irq_src_i,
    input  logic [N_SOURCE-1:0][1:0] trig_i,
    input  logic [N_SOURCE-1:0]      ie_i,
    input  logic [N_SOURCE-1:0]      ip_sw_we_i,
    input  logic [N_SOURCE-1:0]      ip_sw_d_i,
    input  logic                     ack_valid_i,
    input  logic [IDW-1:0]           ack_id_i,
    output logic [N_SOURCE-1:0]      ip_o,
    output logic [N_SOURCE-1:0]      ip_de_o,
    output logic [N_SOURCE-1:0]      irq_pend_o
);
    logic [1:0] wcnt;
    logic       warm;

    always_ff @(posedge clk_i) begin
        if (!rst_ni)          wcnt <= 2'(SYNC_STAGES);
        else if (wcnt != '0)  wcnt <= wcnt - 2'd1;
    end
    assign warm = (wcnt == '0);

    // Ids at or above N_SOURCE match no lane, so out-of-range acks fall away.
    genvar i;
    generate
        for (i = 0; i < N_SOURCE; i++) begin : g_lane
            clic_trig_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .warm_i  (warm),
                .src_i   (irq_src_i[i]),
                .trig_i  (trig_i[i]),
                .sw_we_i (ip_sw_we_i[i]),
                .sw_d_i  (ip_sw_d_i[i]),
                .ack_i   (ack_valid_i && (ack_id_i == IDW'(i))),
                .ip_o    (ip_o[i]),
                .ip_de_o (ip_de_o[i])
            );
        end
    endgenerate

    assign irq_pend_o = ip_o & ie_i;
endmodule

// File: tb/tb_clic_trig_gateway.sv
// Directed bench for clic_trig_gateway: 4 sources, 2-stage synchroniser.

module tb_clic_trig_gateway;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    src, ie, we, wd, ip, de, pend;
    logic [N-1:0][1:0] trig;
    logic            ack_v;
    logic [1:0]      ack_id;
    int              n_tests = 0;
    int              n_fail = 0;

    always #5 clk = ~clk;

    clic_trig_gateway #(.N_SOURCE(N), .SYNC_STAGES(2)) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .irq_src_i   (src),
        .trig_i      (trig),
        .ie_i        (ie),
        .ip_sw_we_i  (we),
        .ip_sw_d_i   (wd),
        .ack_valid_i (ack_v),
        .ack_id_i    (ack_id),
        .ip_o        (ip),
        .ip_de_o     (de),
        .irq_pend_o  (pend)
    );

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        src    = 4'b1001;
        trig   = {2'b11, 2'b00, 2'b01, 2'b01};
        ie     = 4'b1111;
        we     = '0;
        wd     = '0;
        ack_v  = 1'b0;
        ack_id = '0;

        // reset with src0 (edge) and src3 (falling, held high) already active
        step(3);
        chk("rst_ip", ip, 4'b0000);
        chk("rst_de", de, 4'b0000);
        chk("rst_pend", pend, 4'b0000);
        rst_n = 1'b1;
        step(6);
        chk("post_rst_ip", ip, 4'b0000);
        chk("post_rst_de", de, 4'b0000);

        // rising edge on source 1: pending three edges later, one-cycle strobe
        src[1] = 1'b1;
        step(2);
        chk("edge_lat_early", 4'(ip[1]), 4'd0);
        step(1);
        chk("edge_ip", ip, 4'b0010);
        chk("edge_de", de, 4'b0010);
        step(1);
        chk("edge_de_drop", de, 4'b0000);
        src[1] = 1'b0;
        step(4);
        chk("edge_sticky", ip, 4'b0010);

        // ack coinciding with a new edge keeps it; ack alone then clears
        src[1] = 1'b1;
        step(2);
        ack_v = 1'b1; ack_id = 2'd1;
        step(1);
        chk("ack_vs_edge_ip", 4'(ip[1]), 4'd1);
        chk("ack_vs_edge_de", 4'(de[1]), 4'd0);
        step(1);
        chk("ack_clear_ip", 4'(ip[1]), 4'd0);
        chk("ack_clear_de", 4'(de[1]), 4'd1);
        ack_v = 1'b0;

        // software set, ignored ack variants, software clear
        we[1] = 1'b1; wd[1] = 1'b1;
        step(1);
        we[1] = 1'b0; wd[1] = 1'b0;
        chk("sw_set_ip", 4'(ip[1]), 4'd1);
        chk("sw_set_de", 4'(de[1]), 4'd1);
        ack_v = 1'b0; ack_id = 2'd1;
        step(2);
        chk("ack_invalid", 4'(ip[1]), 4'd1);
        ack_v = 1'b1; ack_id = 2'd2;
        step(1);
        ack_v = 1'b0;
        chk("ack_other_id", 4'(ip[1]), 4'd1);
        we[1] = 1'b1; wd[1] = 1'b0;
        step(1);
        we[1] = 1'b0;
        chk("sw_clear", 4'(ip[1]), 4'd0);

        // clearing software write coinciding with an edge: edge wins
        src[1] = 1'b0;
        step(3);
        src[1] = 1'b1;
        step(2);
        we[1] = 1'b1; wd[1] = 1'b0;
        step(1);
        we[1] = 1'b0;
        chk("sw_vs_edge", 4'(ip[1]), 4'd1);

        // level source 2: 5-cycle pulse shows up 3 cycles later for exactly 5 cycles
        src[2] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (k == 5) src[2] = 1'b0;
            chk($sformatf("lvl_k%0d", k), 4'(ip[2]), (k >= 3 && k <= 7) ? 4'd1 : 4'd0);
        end
        we[2] = 1'b1; wd[2] = 1'b1;
        step(1);
        we[2] = 1'b0; wd[2] = 1'b0;
        chk("lvl_sw_ignored", 4'(ip[2]), 4'd0);
        step(1);
        chk("lvl_sw_ignored2", 4'(ip[2]), 4'd0);

        // falling edge on source 3 with enable off
        ie[3] = 1'b0;
        src[3] = 1'b0;
        step(2);
        chk("fall_early", 4'(ip[3]), 4'd0);
        step(1);
        chk("fall_ip", 4'(ip[3]), 4'd1);
        chk("fall_pend_gated", 4'(pend[3]), 4'd0);
        step(3);
        chk("fall_sticky", 4'(ip[3]), 4'd1);
        ie[3] = 1'b1;
        step(1);
        chk("pend_mask", pend, 4'b1010);

        // level-to-edge switch on source 2 holds the last level value
        src[2] = 1'b1;
        step(4);
        chk("switch_pre", 4'(ip[2]), 4'd1);
        trig[2] = 2'b01;
        src[2] = 1'b0;
        step(4);
        chk("switch_hold", 4'(ip[2]), 4'd1);

        we = 4'b0101; wd = 4'b0001;
        step(1);
        we = '0; wd = '0;
        chk("pre_rst_ip", ip, 4'b1011);
        chk("pre_rst_de", de, 4'b0101);

        // mid-run reset with sources 0,1,3 active: nothing pends after release
        rst_n = 1'b0;
        step(1);
        chk("mid_rst_ip", ip, 4'b0000);
        chk("mid_rst_de", de, 4'b0000);
        chk("mid_rst_pend", pend, 4'b0000);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            chk($sformatf("rel_k%0d", k), ip, 4'b0000);
        end
        chk("rel_de", de, 4'b0000);
        src[2] = 1'b1;
        step(3);
        chk("rel_new_edge", ip, 4'b0100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
